// File: rtl/spdif_pkg.sv
// S/PDIF sample pairer shared types, widths and helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spdif_pkg;

  localparam int SAMPLE_W = 24;
  localparam int CNT_W    = 8;
  localparam int LEVEL_W  = SAMPLE_W - 1;

  localparam logic LRCK_LEFT  = 1'b0;
  localparam logic LRCK_RIGHT = 1'b1;

  typedef enum logic {
    WAIT_L = 1'b0,
    HAVE_L = 1'b1
  } pair_state_t;

  // Magnitude of a two's-complement sample in LEVEL_W bits. The most negative
  // code has no positive counterpart, so it clamps to full scale. For every
  // other negative value the low bits of ~s + 1 are the exact magnitude.
  function automatic logic [LEVEL_W-1:0] abs_sat(input logic [SAMPLE_W-1:0] s);
    if (s == {1'b1, {(SAMPLE_W-1){1'b0}}}) begin
      return '1;
    end else if (s[SAMPLE_W-1]) begin
      return (~s[LEVEL_W-1:0]) + 1'b1;
    end else begin
      return s[LEVEL_W-1:0];
    end
  endfunction

endpackage

// File: rtl/spdif_pair_fifo.sv
// Stereo-pair FIFO, first-word fall-through, with synchronous flush.
// Latency: a push at cycle n is visible on dout/!empty at cycle n+1; no bypass.
// Backpressure: exposes full; a push while full is accepted only together with a pop.
//
// Ports:
//   clk, rst_n   clock, async active-low reset (pointers and storage cleared)
//   push, din    write request and WIDTH-bit data
//   pop          consume the head entry (ignored while empty)
//   flush        discard all entries; wins over a same-cycle push and pop
//   dout         head entry (holds stale data while empty)
//   full, empty  occupancy flags
module spdif_pair_fifo #(
  parameter int DEPTH_LOG2 = 2,
  parameter int WIDTH      = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // One extra pointer bit separates the full and empty cases when the
  // index bits are equal.
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic [WIDTH-1:0]    mem [DEPTH];
  logic                wr_en;
  logic                rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr == {~rd_ptr[DEPTH_LOG2], rd_ptr[DEPTH_LOG2-1:0]});

  // When full, a pop frees the head slot, which is exactly the slot the
  // write pointer addresses, so push and pop can both proceed.
  assign wr_en = push && (!full || pop) && !flush;
  assign rd_en = pop && !empty && !flush;

  assign dout = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spdif_sample_pairer.sv
// Pairs S/PDIF left/right subframes into stereo pairs and buffers them for the mixer.
// Latency: pair visible on data_l_o/data_r_o with valid_o one cycle after the right-subframe ack.
// Backpressure: FIFO absorbs ready_i stalls; pairs arriving while full (and not popped) are dropped and counted.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   data_i, ack_i, lrck_i    DAI sample, one-cycle strobe, channel (0 = left, 1 = right)
//   locked_i                 DAI lock; low forces the pairer back to waiting for a left subframe
//   data_l_o, data_r_o       head pair; valid_o = FIFO not empty; ready_i pops the head
//   drop_count_o             saturating count of pairs lost to overflow
//   orphan_count_o           saturating count of unpaired subframes discarded
//   level_l_o, level_r_o,    peak magnitude trackers with clear; present only when
//   level_clr_i              SPDIF_PAIR_LEVEL_EN is defined
module spdif_sample_pairer
  import spdif_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int FLUSH_ON_UNLOCK = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] data_i,
  input  logic                ack_i,
  input  logic                lrck_i,
  input  logic                locked_i,
  output logic [SAMPLE_W-1:0] data_l_o,
  output logic [SAMPLE_W-1:0] data_r_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [CNT_W-1:0]    drop_count_o,
`ifdef SPDIF_PAIR_LEVEL_EN
  output logic [LEVEL_W-1:0]  level_l_o,
  output logic [LEVEL_W-1:0]  level_r_o,
  input  logic                level_clr_i,
`endif
  output logic [CNT_W-1:0]    orphan_count_o
);

  pair_state_t           state;
  logic [SAMPLE_W-1:0]   hold;
  logic                  pair_push;
  logic                  pop;
  logic                  flush;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [2*SAMPLE_W-1:0] fifo_dout;

  // A pair completes when a right subframe arrives with a left one held.
  assign pair_push = ack_i && locked_i && (state == HAVE_L) && (lrck_i == LRCK_RIGHT);
  assign pop       = valid_o && ready_i;
  assign flush     = (FLUSH_ON_UNLOCK != 0) && !locked_i;

  assign valid_o  = !fifo_empty;
  assign data_l_o = fifo_dout[2*SAMPLE_W-1:SAMPLE_W];
  assign data_r_o = fifo_dout[SAMPLE_W-1:0];

  spdif_pair_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
    .WIDTH      (2*SAMPLE_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pair_push),
    .pop   (pop),
    .flush (flush),
    .din   ({hold, data_i}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Pairing FSM and orphan accounting. Lock loss overrides any ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= WAIT_L;
      hold           <= '0;
      orphan_count_o <= '0;
    end else if (!locked_i) begin
      state <= WAIT_L;
    end else if (ack_i) begin
      case (state)
        WAIT_L: begin
          if (lrck_i == LRCK_LEFT) begin
            hold  <= data_i;
            state <= HAVE_L;
          end else if (orphan_count_o != '1) begin
            orphan_count_o <= orphan_count_o + 1'b1;
          end
        end
        HAVE_L: begin
          if (lrck_i == LRCK_RIGHT) begin
            state <= WAIT_L;
          end else begin
            // A second left replaces the first; the first becomes the orphan.
            hold <= data_i;
            if (orphan_count_o != '1) begin
              orphan_count_o <= orphan_count_o + 1'b1;
            end
          end
        end
        default: state <= WAIT_L;
      endcase
    end
  end

  // Overflow only when no same-cycle pop makes room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count_o <= '0;
    end else if (pair_push && fifo_full && !pop && (drop_count_o != '1)) begin
      drop_count_o <= drop_count_o + 1'b1;
    end
  end

`ifdef SPDIF_PAIR_LEVEL_EN
  logic [LEVEL_W-1:0] abs_l;
  logic [LEVEL_W-1:0] abs_r;

  assign abs_l = abs_sat(hold);
  assign abs_r = abs_sat(data_i);

  // Clear restarts the peak from the same-cycle pair if there is one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_l_o <= '0;
      level_r_o <= '0;
    end else if (level_clr_i) begin
      level_l_o <= pair_push ? abs_l : '0;
      level_r_o <= pair_push ? abs_r : '0;
    end else if (pair_push) begin
      if (abs_l > level_l_o) level_l_o <= abs_l;
      if (abs_r > level_r_o) level_r_o <= abs_r;
    end
  end
`endif

endmodule

// File: tb/tb_spdif_sample_pairer.sv
// Directed bench for spdif_sample_pairer with a pair scoreboard.
module tb_spdif_sample_pairer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] data_i = '0;
  logic        ack_i = 1'b0;
  logic        lrck_i = 1'b0;
  logic        locked_i = 1'b1;
  logic [23:0] data_l_o;
  logic [23:0] data_r_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [7:0]  drop_count_o;
  logic [7:0]  orphan_count_o;
`ifdef SPDIF_PAIR_LEVEL_EN
  logic [22:0] level_l_o;
  logic [22:0] level_r_o;
  logic        level_clr_i = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [47:0] sb[$];

  spdif_sample_pairer #(
    .FIFO_DEPTH_LOG2 (2),
    .FLUSH_ON_UNLOCK (1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_i         (data_i),
    .ack_i          (ack_i),
    .lrck_i         (lrck_i),
    .locked_i       (locked_i),
    .data_l_o       (data_l_o),
    .data_r_o       (data_r_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .drop_count_o   (drop_count_o),
`ifdef SPDIF_PAIR_LEVEL_EN
    .level_l_o      (level_l_o),
    .level_r_o      (level_r_o),
    .level_clr_i    (level_clr_i),
`endif
    .orphan_count_o (orphan_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: a pop happens on every cycle with valid_o && ready_i.
  always @(negedge clk) begin
    if (rst_n && valid_o && ready_i) begin
      if (sb.size() == 0) begin
        check("unexpected_pair", {data_l_o, data_r_o}, 48'hx);
      end else begin
        check("pair", {data_l_o, data_r_o}, sb.pop_front());
      end
    end
  end

  // One subframe ack; returns 1 time unit after the sampling edge.
  task automatic sub(input logic lr, input logic [23:0] d);
    ack_i  = 1'b1;
    lrck_i = lr;
    data_i = d;
    @(posedge clk);
    #1;
    ack_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    ready_i = 1'b1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    @(posedge clk);
    #1;
    check({tag, "_sb_empty"}, 48'(sb.size()), 48'd0);
    check({tag, "_valid_low"}, 48'(valid_o), 48'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    check("rst_valid", 48'(valid_o), 48'd0);
    check("rst_data", {data_l_o, data_r_o}, 48'd0);
    check("rst_drop", 48'(drop_count_o), 48'd0);
    check("rst_orphan", 48'(orphan_count_o), 48'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: basic pair, one-cycle latency, popped next cycle
    ready_i = 1'b1;
    sb.push_back({24'h123456, 24'hFEDCBA});
    sub(1'b0, 24'h123456);
    check("t1_valid_before_r", 48'(valid_o), 48'd0);
    sub(1'b1, 24'hFEDCBA);
    check("t1_valid", 48'(valid_o), 48'd1);
    check("t1_data_l", 48'(data_l_o), 48'h123456);
    check("t1_data_r", 48'(data_r_o), 48'hFEDCBA);
    @(posedge clk);
    #1;
    check("t1_popped", 48'(valid_o), 48'd0);

    // 2: orphans R, L, L, R
    sub(1'b1, 24'd1);
    sub(1'b0, 24'd2);
    sub(1'b0, 24'd3);
    sb.push_back({24'd3, 24'd4});
    sub(1'b1, 24'd4);
    repeat (2) @(posedge clk);
    #1;
    check("t2_orphan", 48'(orphan_count_o), 48'd2);
    check("t2_sb_empty", 48'(sb.size()), 48'd0);

    // 3: overflow with ready low, then push+pop while full
    ready_i = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (i <= 4) sb.push_back({24'(i * 16), 24'(i * 16 + 1)});
      sub(1'b0, 24'(i * 16));
      sub(1'b1, 24'(i * 16 + 1));
    end
    check("t3_drop", 48'(drop_count_o), 48'd2);
    check("t3_valid", 48'(valid_o), 48'd1);
    check("t3_head", {data_l_o, data_r_o}, {24'h10, 24'h11});
    sub(1'b0, 24'h70);
    sb.push_back({24'h70, 24'h71});
    ready_i = 1'b1;
    sub(1'b1, 24'h71);
    ready_i = 1'b0;
    check("t3_drop_push_pop", 48'(drop_count_o), 48'd2);
    // Exactly four pops must empty it: pairs 2, 3, 4, 7.
    ready_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    ready_i = 1'b0;
    check("t3_occupancy4", 48'(valid_o), 48'd0);
    check("t3_sb_empty", 48'(sb.size()), 48'd0);

    // 4: loss of lock flushes and resets pairing; ack while unlocked ignored
    for (int i = 0; i < 3; i++) begin
      sb.push_back({24'(i + 24'hA0), 24'(i + 24'hB0)});
      sub(1'b0, 24'(i + 24'hA0));
      sub(1'b1, 24'(i + 24'hB0));
    end
    sub(1'b0, 24'hC0);
    check("t4_valid_before", 48'(valid_o), 48'd1);
    locked_i = 1'b0;
    sub(1'b1, 24'hC1);
    locked_i = 1'b1;
    sb.delete();
    check("t4_flushed", 48'(valid_o), 48'd0);
    check("t4_unlocked_ack_ignored", 48'(orphan_count_o), 48'd2);
    sub(1'b1, 24'hC2);
    check("t4_orphan_after", 48'(orphan_count_o), 48'd3);
    check("t4_no_pair", 48'(valid_o), 48'd0);

    // 5: async reset mid-operation
    for (int i = 0; i < 2; i++) begin
      sb.push_back({24'(i + 24'hD0), 24'(i + 24'hE0)});
      sub(1'b0, 24'(i + 24'hD0));
      sub(1'b1, 24'(i + 24'hE0));
    end
    sub(1'b0, 24'hDD);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    check("t5_valid", 48'(valid_o), 48'd0);
    check("t5_drop", 48'(drop_count_o), 48'd0);
    check("t5_orphan", 48'(orphan_count_o), 48'd0);
    check("t5_data", {data_l_o, data_r_o}, 48'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    sub(1'b1, 24'h55);
    check("t5_fsm_wait_l", 48'(orphan_count_o), 48'd1);
    check("t5_no_pair", 48'(valid_o), 48'd0);
    ready_i = 1'b1;
    sb.push_back({24'h654321, 24'h0ABCDE});
    sub(1'b0, 24'h654321);
    sub(1'b1, 24'h0ABCDE);
    drain("t5");

    // Orphan counter saturation
    for (int i = 0; i < 260; i++) sub(1'b1, 24'(i));
    check("orphan_sat", 48'(orphan_count_o), 48'd255);

    // Drop counter saturation
    ready_i = 1'b0;
    for (int i = 0; i < 260; i++) begin
      if (i < 4) sb.push_back({24'(i + 24'h300), 24'(i + 24'h400)});
      sub(1'b0, 24'(i + 24'h300));
      sub(1'b1, 24'(i + 24'h400));
    end
    check("drop_sat", 48'(drop_count_o), 48'd255);
    drain("drop_sat");

`ifdef SPDIF_PAIR_LEVEL_EN
    // 6: peak level tracking
    level_clr_i = 1'b1;
    @(posedge clk);
    #1;
    level_clr_i = 1'b0;
    check("t6_clr0_l", 48'(level_l_o), 48'd0);
    check("t6_clr0_r", 48'(level_r_o), 48'd0);
    ready_i = 1'b1;
    sb.push_back({24'h800000, 24'h000010});
    sub(1'b0, 24'h800000);
    sub(1'b1, 24'h000010);
    check("t6_level_l", 48'(level_l_o), 48'h7FFFFF);
    check("t6_level_r", 48'(level_r_o), 48'h000010);
    level_clr_i = 1'b1;
    @(posedge clk);
    #1;
    level_clr_i = 1'b0;
    check("t6_clr_l", 48'(level_l_o), 48'd0);
    check("t6_clr_r", 48'(level_r_o), 48'd0);
    sb.push_back({24'hFFFFFF, 24'h000005});
    sub(1'b0, 24'hFFFFFF);
    level_clr_i = 1'b1;
    sub(1'b1, 24'h000005);
    level_clr_i = 1'b0;
    check("t6_clr_push_l", 48'(level_l_o), 48'd1);
    check("t6_clr_push_r", 48'(level_r_o), 48'd5);
    sb.push_back({24'h000002, 24'hFFFFFD});
    sub(1'b0, 24'h000002);
    sub(1'b1, 24'hFFFFFD);
    check("t6_peak_l", 48'(level_l_o), 48'd2);
    check("t6_peak_r", 48'(level_r_o), 48'd5);
    drain("t6");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
